// File: rtl/mouse_bounds_pkg.sv
// Shared types and default tables for the mouse bounds sequencer.
// Contents:
//   step_t      - command order toward the mouse controller (3 bits)
//   state_t     - sequencer FSM states
//   DEF_*       - default parameter values and per-mode tables; mode k sits
//                 in bits [k*VALUE_W +: VALUE_W] of each packed table
//   step_onehot - strobe vector for a step (bit index == step encoding)
//   step_next   - next step in the command order
package mouse_bounds_pkg;

  typedef enum logic [2:0] {
    STEP_MAX_X = 3'd0,
    STEP_MAX_Y = 3'd1,
    STEP_MIN_X = 3'd2,
    STEP_MIN_Y = 3'd3,
    STEP_SET_X = 3'd4,
    STEP_SET_Y = 3'd5
  } step_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int DEF_VALUE_W   = 12;
  localparam int DEF_MODE_W    = 3;
  localparam int DEF_NUM_MODES = 4;
  localparam int DEF_CURSOR_W  = 16;
  localparam int DEF_CURSOR_H  = 16;

  // Concatenations are written highest mode first: {mode3, mode2, mode1, mode0}.
  localparam logic [47:0] DEF_MIN_X_TBL = {12'd0,    12'd411, 12'd361, 12'd0};
  localparam logic [47:0] DEF_MIN_Y_TBL = {12'd0,    12'd417, 12'd367, 12'd0};
  localparam logic [47:0] DEF_MAX_X_TBL = {12'd1019, 12'd611, 12'd661, 12'd1019};
  localparam logic [47:0] DEF_MAX_Y_TBL = {12'd763,  12'd617, 12'd667, 12'd763};
  localparam logic [47:0] DEF_CTR_X_TBL = {12'd0,    12'd511, 12'd511, 12'd0};
  localparam logic [47:0] DEF_CTR_Y_TBL = {12'd0,    12'd460, 12'd460, 12'd0};

  localparam logic [3:0] DEF_RECENTER_MASK   = 4'b0110;
  localparam logic [3:0] DEF_CURSOR_SUB_MASK = 4'b0110;

  function automatic logic [5:0] step_onehot(input step_t s);
    return 6'b000001 << s;
  endfunction

  function automatic step_t step_next(input step_t s);
    return (s == STEP_SET_Y) ? STEP_SET_Y : step_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/mouse_bounds_sequencer_if.sv
// Command bus from the bounds sequencer to the mouse controller.
//   value     - command payload
//   setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y - command strobes,
//               at most one high; strobe and value hold until accepted
//   cmd_ready - controller accepts the current command on this edge
// Modports: master = sequencer side, slave = controller side.
interface mouse_bounds_sequencer_if #(
  parameter int VALUE_W = 12
);
  logic [VALUE_W-1:0] value;
  logic               setmax_x;
  logic               setmax_y;
  logic               setmin_x;
  logic               setmin_y;
  logic               set_x;
  logic               set_y;
  logic               cmd_ready;

  modport master (
    output value, setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y,
    input  cmd_ready
  );

  modport slave (
    input  value, setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y,
    output cmd_ready
  );
endinterface

// File: rtl/mouse_bounds_lut.sv
// Combinational per-mode value lookup.
// Ports:
//   mode      in  mode to look up (out-of-range modes read as mode 0)
//   step      in  command step
//   value     out payload for (mode, step) after cursor compensation/clamp
//   last_step out step is the final command of this mode's sequence
module mouse_bounds_lut
  import mouse_bounds_pkg::*;
#(
  parameter int VALUE_W   = DEF_VALUE_W,
  parameter int MODE_W    = DEF_MODE_W,
  parameter int NUM_MODES = DEF_NUM_MODES,
  parameter int CURSOR_W  = DEF_CURSOR_W,
  parameter int CURSOR_H  = DEF_CURSOR_H,
  parameter logic [NUM_MODES*VALUE_W-1:0] MIN_X_TBL = DEF_MIN_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MIN_Y_TBL = DEF_MIN_Y_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MAX_X_TBL = DEF_MAX_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MAX_Y_TBL = DEF_MAX_Y_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] CTR_X_TBL = DEF_CTR_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] CTR_Y_TBL = DEF_CTR_Y_TBL,
  parameter logic [NUM_MODES-1:0] RECENTER_MASK   = DEF_RECENTER_MASK,
  parameter logic [NUM_MODES-1:0] CURSOR_SUB_MASK = DEF_CURSOR_SUB_MASK
) (
  input  logic [MODE_W-1:0]  mode,
  input  step_t              step,
  output logic [VALUE_W-1:0] value,
  output logic               last_step
);

  localparam logic [VALUE_W:0] CUR_W_EXT = (VALUE_W+1)'(CURSOR_W);
  localparam logic [VALUE_W:0] CUR_H_EXT = (VALUE_W+1)'(CURSOR_H);

  // Subtract one guard bit wider so an oversized cursor shows up as a set
  // MSB instead of wrapping; either way the limit falls back to the minimum.
  function automatic logic [VALUE_W-1:0] limit_max(
    input logic [VALUE_W-1:0] mx,
    input logic [VALUE_W-1:0] mn,
    input logic [VALUE_W:0]   sub
  );
    logic [VALUE_W:0] d;
    d = {1'b0, mx} - sub;
    if (d[VALUE_W] || (d[VALUE_W-1:0] < mn)) return mn;
    return d[VALUE_W-1:0];
  endfunction

  function automatic logic [VALUE_W-1:0] clamp(
    input logic [VALUE_W-1:0] c,
    input logic [VALUE_W-1:0] lo,
    input logic [VALUE_W-1:0] hi
  );
    if (c < lo) return lo;
    if (c > hi) return hi;
    return c;
  endfunction

  int                 mi;
  int                 sh;
  logic [NUM_MODES-1:0] rc_sh;
  logic [NUM_MODES-1:0] cs_sh;
  logic               recenter;
  logic               cur_sub;
  logic [VALUE_W-1:0] min_x, min_y, max_x, max_y, ctr_x, ctr_y;
  logic [VALUE_W-1:0] eff_x, eff_y;

  always_comb begin
    mi       = (int'(mode) < NUM_MODES) ? int'(mode) : 0;
    sh       = mi * VALUE_W;
    rc_sh    = RECENTER_MASK >> mi;
    cs_sh    = CURSOR_SUB_MASK >> mi;
    recenter = rc_sh[0];
    cur_sub  = cs_sh[0];

    min_x = VALUE_W'(MIN_X_TBL >> sh);
    min_y = VALUE_W'(MIN_Y_TBL >> sh);
    max_x = VALUE_W'(MAX_X_TBL >> sh);
    max_y = VALUE_W'(MAX_Y_TBL >> sh);
    ctr_x = VALUE_W'(CTR_X_TBL >> sh);
    ctr_y = VALUE_W'(CTR_Y_TBL >> sh);

    eff_x = limit_max(max_x, min_x, cur_sub ? CUR_W_EXT : '0);
    eff_y = limit_max(max_y, min_y, cur_sub ? CUR_H_EXT : '0);

    value = '0;
    case (step)
      STEP_MAX_X: value = eff_x;
      STEP_MAX_Y: value = eff_y;
      STEP_MIN_X: value = min_x;
      STEP_MIN_Y: value = min_y;
      STEP_SET_X: value = clamp(ctr_x, min_x, eff_x);
      STEP_SET_Y: value = clamp(ctr_y, min_y, eff_y);
      default:    value = '0;
    endcase

    last_step = (step == STEP_SET_Y) || ((step == STEP_MIN_Y) && !recenter);
  end

endmodule

// File: rtl/mouse_bounds_sequencer.sv
// Programs the mouse controller's cursor limits (and optional recentre
// position) whenever the requested mouse mode changes or a reload is forced.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mouse_mode    requested mode (level)
//   force_reload  pulse: re-run the active mode's sequence (ignored while busy)
//   cmd           command bus toward the controller (master side)
//   active_mode   mode programmed or being programmed
//   busy          sequence in progress
//   done          pulse when the final command of a sequence is accepted
//   mode_err      pulse when an out-of-range mode is first requested
//
// state | meaning
// IDLE  | limits programmed; watch for mode change / force_reload
// ISSUE | one command on the bus (or about to be loaded), held until accepted
module mouse_bounds_sequencer
  import mouse_bounds_pkg::*;
#(
  parameter int VALUE_W   = DEF_VALUE_W,
  parameter int MODE_W    = DEF_MODE_W,
  parameter int NUM_MODES = DEF_NUM_MODES,
  parameter int CURSOR_W  = DEF_CURSOR_W,
  parameter int CURSOR_H  = DEF_CURSOR_H,
  parameter logic [NUM_MODES*VALUE_W-1:0] MIN_X_TBL = DEF_MIN_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MIN_Y_TBL = DEF_MIN_Y_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MAX_X_TBL = DEF_MAX_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] MAX_Y_TBL = DEF_MAX_Y_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] CTR_X_TBL = DEF_CTR_X_TBL,
  parameter logic [NUM_MODES*VALUE_W-1:0] CTR_Y_TBL = DEF_CTR_Y_TBL,
  parameter logic [NUM_MODES-1:0] RECENTER_MASK   = DEF_RECENTER_MASK,
  parameter logic [NUM_MODES-1:0] CURSOR_SUB_MASK = DEF_CURSOR_SUB_MASK
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MODE_W-1:0]         mouse_mode,
  input  logic                      force_reload,
  mouse_bounds_sequencer_if.master  cmd,
  output logic [MODE_W-1:0]         active_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      mode_err
);

  state_t             state_q;
  step_t              step_q;
  logic [5:0]         strobe_q;
  logic [VALUE_W-1:0] value_q;
  logic               last_q;
  logic [MODE_W-1:0]  mode_prev;

  logic               pending;
  logic               mode_ok;
  logic               mode_change;
  logic [MODE_W-1:0]  tgt_mode;
  step_t              tgt_step;
  logic [VALUE_W-1:0] lut_value;
  logic               lut_last;

  assign pending = |strobe_q;

  // Select what the bus should carry after the coming edge. A pending
  // command that gets accepted while a different valid mode is requested
  // restarts at MAX_X of the new mode instead of advancing.
  always_comb begin
    mode_ok     = int'(mouse_mode) < NUM_MODES;
    mode_change = mode_ok && (mouse_mode != active_mode);
    tgt_mode    = active_mode;
    tgt_step    = step_q;
    if ((state_q == ISSUE) && pending) begin
      if (mode_change) begin
        tgt_mode = mouse_mode;
        tgt_step = STEP_MAX_X;
      end else begin
        tgt_step = step_next(step_q);
      end
    end
  end

  mouse_bounds_lut #(
    .VALUE_W        (VALUE_W),
    .MODE_W         (MODE_W),
    .NUM_MODES      (NUM_MODES),
    .CURSOR_W       (CURSOR_W),
    .CURSOR_H       (CURSOR_H),
    .MIN_X_TBL      (MIN_X_TBL),
    .MIN_Y_TBL      (MIN_Y_TBL),
    .MAX_X_TBL      (MAX_X_TBL),
    .MAX_Y_TBL      (MAX_Y_TBL),
    .CTR_X_TBL      (CTR_X_TBL),
    .CTR_Y_TBL      (CTR_Y_TBL),
    .RECENTER_MASK  (RECENTER_MASK),
    .CURSOR_SUB_MASK(CURSOR_SUB_MASK)
  ) u_lut (
    .mode     (tgt_mode),
    .step     (tgt_step),
    .value    (lut_value),
    .last_step(lut_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE;
      step_q      <= STEP_MAX_X;
      strobe_q    <= '0;
      value_q     <= '0;
      last_q      <= 1'b0;
      active_mode <= '0;
      mode_prev   <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      done      <= 1'b0;
      mode_prev <= mouse_mode;
      // Pulse once per new out-of-range request rather than every cycle it is held.
      mode_err  <= !mode_ok && (mouse_mode != mode_prev);

      case (state_q)
        IDLE: begin
          if (mode_change || force_reload) begin
            if (mode_change) active_mode <= mouse_mode;
            step_q  <= STEP_MAX_X;
            state_q <= ISSUE;
            busy    <= 1'b1;
          end
        end

        ISSUE: begin
          if (!pending) begin
            // Entry from IDLE or reset: load the first command of the sequence.
            step_q   <= tgt_step;
            strobe_q <= step_onehot(tgt_step);
            value_q  <= lut_value;
            last_q   <= lut_last;
          end else if (cmd.cmd_ready) begin
            if (last_q && !mode_change) begin
              strobe_q <= '0;
              last_q   <= 1'b0;
              state_q  <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              if (mode_change) active_mode <= mouse_mode;
              step_q   <= tgt_step;
              strobe_q <= step_onehot(tgt_step);
              value_q  <= lut_value;
              last_q   <= lut_last;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.value    = value_q;
  assign cmd.setmax_x = strobe_q[0];
  assign cmd.setmax_y = strobe_q[1];
  assign cmd.setmin_x = strobe_q[2];
  assign cmd.setmin_y = strobe_q[3];
  assign cmd.set_x    = strobe_q[4];
  assign cmd.set_y    = strobe_q[5];

endmodule

// File: tb/tb_mouse_bounds_sequencer.sv
`timescale 1ns/1ps
module tb_mouse_bounds_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mouse_mode = 3'd0;
  logic       force_reload = 1'b0;
  logic [2:0] active_mode;
  logic       busy, done, mode_err;
  logic [5:0] strb;

  int n_vec = 0;
  int n_err = 0;

  mouse_bounds_sequencer_if #(.VALUE_W(12)) cmd ();

  mouse_bounds_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mouse_mode  (mouse_mode),
    .force_reload(force_reload),
    .cmd         (cmd),
    .active_mode (active_mode),
    .busy        (busy),
    .done        (done),
    .mode_err    (mode_err)
  );

  always #5 clk = ~clk;

  assign strb = {cmd.set_y, cmd.set_x, cmd.setmin_y, cmd.setmin_x, cmd.setmax_y, cmd.setmax_x};

  // Reference tables, index = mode.
  int min_x_t [4] = '{0, 361, 411, 0};
  int min_y_t [4] = '{0, 367, 417, 0};
  int max_x_t [4] = '{1019, 661, 611, 1019};
  int max_y_t [4] = '{763, 667, 617, 763};
  int ctr_x_t [4] = '{0, 511, 511, 0};
  int ctr_y_t [4] = '{0, 460, 460, 0};
  bit recenter_t [4] = '{0, 1, 1, 0};
  bit cursub_t   [4] = '{0, 1, 1, 0};

  // Expected payload of command number s (0..5 in MAX_X..SET_Y order) for mode m.
  function automatic int exp_val(int m, int s);
    int ex, ey, c;
    ex = max_x_t[m] - (cursub_t[m] ? 16 : 0);
    ey = max_y_t[m] - (cursub_t[m] ? 16 : 0);
    if (ex < min_x_t[m]) ex = min_x_t[m];
    if (ey < min_y_t[m]) ey = min_y_t[m];
    case (s)
      0: return ex;
      1: return ey;
      2: return min_x_t[m];
      3: return min_y_t[m];
      4: begin
        c = ctr_x_t[m];
        if (c < min_x_t[m]) c = min_x_t[m];
        if (c > ex) c = ex;
        return c;
      end
      default: begin
        c = ctr_y_t[m];
        if (c < min_y_t[m]) c = min_y_t[m];
        if (c > ey) c = ey;
        return c;
      end
    endcase
  endfunction

  function automatic int seq_len(int m);
    return recenter_t[m] ? 6 : 4;
  endfunction

  task automatic test_reset();
    logic [5:0] es;
    rst = 1'b1; cmd.cmd_ready = 1'b1; mouse_mode = 3'd0; force_reload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (strb !== 6'd0 || cmd.value !== 12'd0) begin
      n_err++; $display("FAIL reset_bus: strobes=%b value=%0d, want 000000/0", strb, cmd.value);
    end
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || mode_err !== 1'b0 || active_mode !== 3'd0) begin
      n_err++; $display("FAIL reset_status: busy=%b done=%b err=%b mode=%0d, want 1/0/0/0",
                        busy, done, mode_err, active_mode);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      es = 6'(1 << i);
      n_vec++;
      if (strb !== es || cmd.value !== 12'(exp_val(0, i))) begin
        n_err++; $display("FAIL reset_seq[%0d]: strobes=%b value=%0d, want %b/%0d",
                          i, strb, cmd.value, es, exp_val(0, i));
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || strb !== 6'd0) begin
      n_err++; $display("FAIL reset_done: done=%b busy=%b strobes=%b, want 1/0/000000", done, busy, strb);
    end
  endtask

  task automatic test_mode_change(input int m);
    logic [5:0] es;
    cmd.cmd_ready = 1'b1;
    mouse_mode = 3'(m);
    @(negedge clk);
    n_vec++;
    if (active_mode !== 3'(m) || busy !== 1'b1 || strb !== 6'd0) begin
      n_err++; $display("FAIL change_latch: mode=%0d busy=%b strobes=%b, want %0d/1/000000",
                        active_mode, busy, strb, m);
    end
    for (int i = 0; i < seq_len(m); i++) begin
      @(negedge clk);
      es = 6'(1 << i);
      n_vec++;
      if (strb !== es || cmd.value !== 12'(exp_val(m, i))) begin
        n_err++; $display("FAIL change_seq[%0d]: strobes=%b value=%0d, want %b/%0d",
                          i, strb, cmd.value, es, exp_val(m, i));
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || strb !== 6'd0 || active_mode !== 3'(m)) begin
      n_err++; $display("FAIL change_done: done=%b busy=%b strobes=%b mode=%0d, want 1/0/000000/%0d",
                        done, busy, strb, active_mode, m);
    end
  endtask

  task automatic test_stall();
    int idx = 0, stalls = 0, vis = 0, cyc = 0;
    bit got_done = 0;
    logic [5:0] es;
    mouse_mode = 3'd1; cmd.cmd_ready = 1'b1;
    force_reload = 1'b1;
    @(negedge clk);
    force_reload = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || strb !== 6'd0) begin
      n_err++; $display("FAIL stall_start: busy=%b strobes=%b, want 1/000000", busy, strb);
    end
    while (cyc < 30 && !got_done) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) got_done = 1;
      else begin
        es = 6'(1 << idx);
        vis++;
        n_vec++;
        if (strb !== es || cmd.value !== 12'(exp_val(1, idx))) begin
          n_err++; $display("FAIL stall_seq[%0d]: strobes=%b value=%0d, want %b/%0d",
                            idx, strb, cmd.value, es, exp_val(1, idx));
        end
        if (idx == 2 && stalls < 3) begin cmd.cmd_ready = 1'b0; stalls++; end
        else begin cmd.cmd_ready = 1'b1; idx++; end
      end
    end
    cmd.cmd_ready = 1'b1;
    n_vec++;
    if (!got_done || vis != 9 || idx != 6 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_total: done_seen=%0d cycles=%0d accepted=%0d busy=%b, want 1/9/6/0",
                        got_done, vis, idx, busy);
    end
  endtask

  task automatic test_invalid_mode();
    int errs = 0, idx = 0, cyc = 0;
    bit got_done = 0;
    logic [5:0] es;
    mouse_mode = 3'd5; cmd.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mode_err === 1'b1) errs++;
      n_vec++;
      if (strb !== 6'd0 || busy !== 1'b0 || active_mode !== 3'd1) begin
        n_err++; $display("FAIL invalid_idle[%0d]: strobes=%b busy=%b mode=%0d, want 000000/0/1",
                          i, strb, busy, active_mode);
      end
    end
    n_vec++;
    if (errs != 1) begin
      n_err++; $display("FAIL invalid_err_pulses: got %0d, want 1", errs);
    end
    errs = 0;
    force_reload = 1'b1;
    @(negedge clk);
    force_reload = 1'b0;
    while (cyc < 20 && !got_done) begin
      @(negedge clk); cyc++;
      if (mode_err === 1'b1) errs++;
      force_reload = 1'b0;
      if (done === 1'b1) got_done = 1;
      else begin
        es = 6'(1 << idx);
        n_vec++;
        if (strb !== es || cmd.value !== 12'(exp_val(1, idx))) begin
          n_err++; $display("FAIL reload_seq[%0d]: strobes=%b value=%0d, want %b/%0d",
                            idx, strb, cmd.value, es, exp_val(1, idx));
        end
        if (idx == 2) force_reload = 1'b1;
        idx++;
      end
    end
    force_reload = 1'b0;
    n_vec++;
    if (!got_done || idx != 6 || errs != 0 || active_mode !== 3'd1) begin
      n_err++; $display("FAIL reload_total: done_seen=%0d accepted=%0d errs=%0d mode=%0d, want 1/6/0/1",
                        got_done, idx, errs, active_mode);
    end
  endtask

  task automatic test_midseq_change();
    int em = 1, idx = 0, acc = 0, cyc = 0;
    bit changed = 0, got_done = 0;
    logic [5:0] es;
    mouse_mode = 3'd1; cmd.cmd_ready = 1'b1;
    force_reload = 1'b1;
    @(negedge clk);
    force_reload = 1'b0;
    while (cyc < 30 && !got_done) begin
      @(negedge clk); cyc++;
      if (done === 1'b1) got_done = 1;
      else begin
        es = 6'(1 << idx);
        n_vec++;
        if (strb !== es || cmd.value !== 12'(exp_val(em, idx))) begin
          n_err++; $display("FAIL midseq[m%0d s%0d]: strobes=%b value=%0d, want %b/%0d",
                            em, idx, strb, cmd.value, es, exp_val(em, idx));
        end
        if (em == 1 && idx == 1 && !changed) begin
          mouse_mode = 3'd2; cmd.cmd_ready = 1'b0; changed = 1;
        end else begin
          cmd.cmd_ready = 1'b1; acc++;
          if (int'(mouse_mode) != em) begin em = int'(mouse_mode); idx = 0; end
          else idx++;
        end
      end
    end
    n_vec++;
    if (!got_done || acc != 8 || active_mode !== 3'd2) begin
      n_err++; $display("FAIL midseq_total: done_seen=%0d accepted=%0d mode=%0d, want 1/8/2",
                        got_done, acc, active_mode);
    end
  endtask

  task automatic test_rst_midseq();
    bit found = 0;
    logic [5:0] es;
    cmd.cmd_ready = 1'b1;
    mouse_mode = 3'd3;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (strb === 6'b001000) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL rst_reach_min_y: strobes=%b, want 001000 within 10 cycles", strb);
    end
    rst = 1'b1; mouse_mode = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (strb !== 6'd0 || busy !== 1'b1 || active_mode !== 3'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: strobes=%b busy=%b mode=%0d done=%b, want 000000/1/0/0",
                        strb, busy, active_mode, done);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      es = 6'(1 << i);
      n_vec++;
      if (strb !== es || cmd.value !== 12'(exp_val(0, i))) begin
        n_err++; $display("FAIL rst_seq[%0d]: strobes=%b value=%0d, want %b/%0d",
                          i, strb, cmd.value, es, exp_val(0, i));
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_done: done=%b busy=%b, want 1/0", done, busy);
    end
  endtask

  // Random mode requests, reloads and back-pressure against a sequence-level model.
  task automatic test_random();
    int ex_active = 0, ex_idx = 0, prev = 0, nm = 0;
    bit in_seq = 0, gap = 0, ex_done = 0, ex_err = 0, cr, fr, valid, chg;
    logic [5:0] es;
    mouse_mode = 3'd0; cmd.cmd_ready = 1'b1; force_reload = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      es = (in_seq && !gap) ? 6'(1 << ex_idx) : 6'd0;
      n_vec++;
      if (strb !== es || (es != 6'd0 && cmd.value !== 12'(exp_val(ex_active, ex_idx)))) begin
        n_err++; $display("FAIL random_bus[%0d]: strobes=%b value=%0d, want %b/%0d",
                          c, strb, cmd.value, es, (es != 6'd0) ? exp_val(ex_active, ex_idx) : 0);
      end
      n_vec++;
      if (busy !== in_seq || done !== ex_done || mode_err !== ex_err || active_mode !== 3'(ex_active)) begin
        n_err++; $display("FAIL random_status[%0d]: busy=%b done=%b err=%b mode=%0d, want %0d/%0d/%0d/%0d",
                          c, busy, done, mode_err, active_mode, in_seq, ex_done, ex_err, ex_active);
      end
      if ($urandom_range(0, 9) == 0) nm = int'($urandom_range(0, 5));
      cr = ($urandom_range(0, 3) != 0);
      fr = ($urandom_range(0, 15) == 0);
      mouse_mode = 3'(nm); cmd.cmd_ready = cr; force_reload = fr;

      valid = (nm < 4);
      chg = valid && (nm != ex_active);
      ex_err = !valid && (nm != prev);
      prev = nm;
      ex_done = 0;
      if (!in_seq) begin
        if (chg) begin ex_active = nm; ex_idx = 0; in_seq = 1; gap = 1; end
        else if (fr) begin ex_idx = 0; in_seq = 1; gap = 1; end
      end else if (gap) begin
        gap = 0;
      end else if (cr) begin
        if (chg) begin ex_active = nm; ex_idx = 0; end
        else if (ex_idx == seq_len(ex_active) - 1) begin in_seq = 0; ex_done = 1; end
        else ex_idx++;
      end
    end
    force_reload = 1'b0;
  endtask

  initial begin
    cmd.cmd_ready = 1'b1;
    test_reset();
    test_mode_change(1);
    test_stall();
    test_invalid_mode();
    test_midseq_change();
    test_rst_midseq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
